// File: rtl/jk_excitation_counter.sv
// JK-modelled up/down/complement counter with a one-shot load handshake.
// Each bit behaves as a JK flip-flop: a target state is chosen, the JK
// excitation needed to reach it is derived per bit, and the registered
// state advances only through the JK characteristic equation.
//
// state | meaning
// IDLE  | load_ready high; target comes from mode, or from load_data on accept
// LOAD  | load_ready low for one cycle; target is the current state (hold)
module jk_excitation_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] inv,
   output logic             wrap
);

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   state_t           state;
   logic             ready_q;
   logic             accept;
   logic             wrap_next;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] out_next;

   // Handshake: readiness is a registered FSM output, forced low during reset.
   assign load_ready = ready_q & ~rst;
   assign accept     = load_valid & load_ready;
   assign inv        = ~out;

   // Target selection; wrap is flagged only for counting past a boundary.
   always_comb begin
      nxt       = out;
      wrap_next = 1'b0;
      if (state == IDLE) begin
         if (accept) begin
            nxt = load_data;
         end else begin
            case (mode)
               2'b01: begin
                  nxt       = out + 1'b1;
                  wrap_next = (out == ALL_ONES);
               end
               2'b10: begin
                  nxt       = out - 1'b1;
                  wrap_next = (out == ZERO);
               end
               2'b11:   nxt = ~out;
               default: nxt = out;
            endcase
         end
      end
   end

   // Excitation table; don't-care entries resolve to 0 and reset silences both.
   always_comb begin
      if (rst) begin
         j = '0;
         k = '0;
      end else begin
         j = nxt & ~out;
         k = ~nxt & out;
      end
   end

   // Characteristic equation Q+ = J.Q' + K'.Q applied bitwise.
   assign out_next = (j & ~out) | (~k & out);

   // State bits advance only through the JK characteristic result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
      end else begin
         out <= out_next;
      end
   end

   // Load FSM with registered ready and wrap outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready_q <= 1'b1;
         wrap    <= 1'b0;
      end else begin
         wrap <= wrap_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= LOAD;
                  ready_q <= 1'b0;
               end
            end
            LOAD: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excitation_counter.sv
// Self-checking bench for jk_excitation_counter (WIDTH=4): directed scenarios
// plus a random stream, with expected registered state queued per edge.
module tb_jk_excitation_counter;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [1:0]   mode;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic [W-1:0] out;
   logic [W-1:0] inv;
   logic         wrap;

   int vectors;
   int miscompares;

   typedef struct packed {
      logic [W-1:0] out;
      logic         wrap;
   } exp_t;

   exp_t sb[$];

   // reference model state
   logic [W-1:0] m_out;
   logic         m_idle;

   jk_excitation_counter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .j          (j),
      .k          (k),
      .out        (out),
      .inv        (inv),
      .wrap       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle with the currently driven inputs: check combinational
   // outputs against the model, queue expected state, clock, then compare.
   task automatic cycle();
      logic         rdy;
      logic         acc;
      logic [W-1:0] tgt;
      logic [W-1:0] ej;
      logic [W-1:0] ek;
      logic         ewrap;
      logic         nidle;
      exp_t         e;
      #1;
      rdy   = !rst && m_idle;
      acc   = load_valid && rdy;
      ewrap = 1'b0;
      if (rst) begin
         tgt   = '0;
         ej    = '0;
         ek    = '0;
         nidle = 1'b1;
      end else begin
         if (!m_idle)  tgt = m_out;
         else if (acc) tgt = load_data;
         else begin
            case (mode)
               2'b01:   tgt = m_out + 4'd1;
               2'b10:   tgt = m_out - 4'd1;
               2'b11:   tgt = ~m_out;
               default: tgt = m_out;
            endcase
            ewrap = (mode == 2'b01 && m_out == 4'hF) || (mode == 2'b10 && m_out == 4'h0);
         end
         // excitation table, bit by bit
         for (int b = 0; b < W; b++) begin
            case ({m_out[b], tgt[b]})
               2'b01:   begin ej[b] = 1'b1; ek[b] = 1'b0; end
               2'b10:   begin ej[b] = 1'b0; ek[b] = 1'b1; end
               default: begin ej[b] = 1'b0; ek[b] = 1'b0; end
            endcase
         end
         nidle = m_idle ? !acc : 1'b1;
      end
      vectors++;
      if (j !== ej) begin
         miscompares++;
         $display("FAIL j: got %b expected %b at %0t", j, ej, $time);
      end
      vectors++;
      if (k !== ek) begin
         miscompares++;
         $display("FAIL k: got %b expected %b at %0t", k, ek, $time);
      end
      vectors++;
      if (load_ready !== rdy) begin
         miscompares++;
         $display("FAIL load_ready: got %b expected %b at %0t", load_ready, rdy, $time);
      end
      e.out  = tgt;
      e.wrap = ewrap;
      sb.push_back(e);
      @(posedge clk);
      #1;
      m_out  = tgt;
      m_idle = nidle;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         if (out !== e.out || inv !== ~e.out || wrap !== e.wrap) begin
            miscompares++;
            $display("FAIL state: got out=%h inv=%h wrap=%b expected out=%h inv=%h wrap=%b at %0t",
                     out, inv, wrap, e.out, ~e.out, e.wrap, $time);
         end
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] md, input logic lv, input logic [W-1:0] ld);
      rst        = r;
      mode       = md;
      load_valid = lv;
      load_data  = ld;
   endtask

   // Put the counter at value v through a load and return to IDLE.
   task automatic preset(input logic [W-1:0] v);
      drive(1'b0, 2'b00, 1'b1, v);
      cycle();
      drive(1'b0, 2'b00, 1'b0, 4'h0);
      cycle();
   endtask

   task automatic test_reset();
      drive(1'b1, 2'b01, 1'b1, 4'hA);
      cycle();
      drive(1'b1, 2'b11, 1'b0, 4'h3);
      #1;
      vectors++;
      if (j !== 4'h0 || k !== 4'h0 || load_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_quiet: got j=%b k=%b rdy=%b expected 0000 0000 0", j, k, load_ready);
      end
      cycle();
      vectors++;
      if (out !== 4'h0 || inv !== 4'hF || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got out=%h inv=%h wrap=%b expected 0 f 0", out, inv, wrap);
      end
   endtask

   task automatic test_count_up();
      int wraps;
      int wrap_at;
      drive(1'b1, 2'b00, 1'b0, 4'h0);
      cycle();
      wraps   = 0;
      wrap_at = -1;
      for (int c = 0; c < 17; c++) begin
         drive(1'b0, 2'b01, 1'b0, 4'h0);
         cycle();
         if (wrap === 1'b1) begin
            wraps++;
            wrap_at = c;
         end
      end
      vectors++;
      if (wraps != 1 || wrap_at != 15) begin
         miscompares++;
         $display("FAIL count_up_wrap: got %0d pulses at step %0d expected 1 at step 15", wraps, wrap_at);
      end
      vectors++;
      if (out !== 4'h1) begin
         miscompares++;
         $display("FAIL count_up_final: got %h expected 1", out);
      end
   endtask

   task automatic test_count_down();
      drive(1'b1, 2'b00, 1'b0, 4'h0);
      cycle();
      drive(1'b0, 2'b10, 1'b0, 4'h0);
      #1;
      vectors++;
      if (j !== 4'b1111 || k !== 4'b0000) begin
         miscompares++;
         $display("FAIL down_excite: got j=%b k=%b expected 1111 0000", j, k);
      end
      cycle();
      vectors++;
      if (out !== 4'hF || inv !== 4'h0 || wrap !== 1'b1) begin
         miscompares++;
         $display("FAIL down_underflow: got out=%h inv=%h wrap=%b expected f 0 1", out, inv, wrap);
      end
   endtask

   task automatic test_load();
      preset(4'h5);
      drive(1'b0, 2'b01, 1'b1, 4'hA);
      #1;
      vectors++;
      if (j !== 4'b1010 || k !== 4'b0101 || load_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL load_excite: got j=%b k=%b rdy=%b expected 1010 0101 1", j, k, load_ready);
      end
      cycle();
      vectors++;
      if (out !== 4'hA || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL load_value: got out=%h wrap=%b expected a 0", out, wrap);
      end
      drive(1'b0, 2'b01, 1'b1, 4'h3);
      #1;
      vectors++;
      if (load_ready !== 1'b0 || j !== 4'h0 || k !== 4'h0) begin
         miscompares++;
         $display("FAIL load_busy: got rdy=%b j=%b k=%b expected 0 0000 0000", load_ready, j, k);
      end
      cycle();
      vectors++;
      if (out !== 4'hA) begin
         miscompares++;
         $display("FAIL load_hold: got out=%h expected a", out);
      end
      drive(1'b0, 2'b00, 1'b0, 4'h0);
      cycle();
   endtask

   task automatic test_complement();
      preset(4'h6);
      drive(1'b0, 2'b11, 1'b0, 4'h0);
      #1;
      vectors++;
      if (j !== 4'b1001 || k !== 4'b0110) begin
         miscompares++;
         $display("FAIL compl_excite: got j=%b k=%b expected 1001 0110", j, k);
      end
      cycle();
      vectors++;
      if (out !== 4'h9 || inv !== 4'h6 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL compl_value: got out=%h inv=%h wrap=%b expected 9 6 0", out, inv, wrap);
      end
   endtask

   task automatic test_reset_load();
      preset(4'hC);
      drive(1'b1, 2'b01, 1'b1, 4'h7);
      cycle();
      drive(1'b0, 2'b00, 1'b0, 4'h0);
      #1;
      vectors++;
      if (out !== 4'h0 || load_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_load: got out=%h rdy=%b expected 0 1", out, load_ready);
      end
      cycle();
      vectors++;
      if (out !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_load_replay: got out=%h expected 0", out);
      end
   endtask

   task automatic test_random();
      int xs;
      xs = 0;
      for (int c = 0; c < 1000; c++) begin
         drive(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
         cycle();
         if ($isunknown({out, inv, j, k, wrap, load_ready})) xs++;
      end
      vectors++;
      if (xs != 0) begin
         miscompares++;
         $display("FAIL random_x: got %0d cycles with X expected 0", xs);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_out       = '0;
      m_idle      = 1'b1;
      drive(1'b1, 2'b00, 1'b0, 4'h0);
      @(posedge clk);
      #1;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_complement();
      test_reset_load();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
